// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle ripple-borrow subtractor computing
// D = X - Y - Bin over WIDTH bits, DIGIT bits per clock, LSB digit first.
// A start/ready/done handshake fronts it; D/Bout/ovf are shadow registers
// that only update on the edge that finishes an operation.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Working registers: operands shift right one digit per RUN edge so the
  // active slice always sits at bit 0; the result fills in from the top.
  logic [WIDTH-1:0] xr, yr, res;
  logic             br;
  logic             xmsb, ymsb;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [DIGIT-1:0]       ds;
  logic                   bchain;
  logic                   b_nx;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       res_nx;

  assign last = (cnt == CW'(N - 1));

  // Ripple one DIGIT-bit slice through full-subtractor cells.
  always_comb begin
    // NOTE: every variable gets a default before any branch or loop so no
    // path leaves it unassigned, which would infer a latch.
    ds     = '0;
    bchain = br;
    for (int i = 0; i < DIGIT; i++) begin
      // NOTE: blocking assignments here are deliberate: bchain must carry
      // the borrow from bit i into bit i+1 within the same evaluation.
      ds[i]  = xr[i] ^ yr[i] ^ bchain;
      bchain = (~xr[i] & yr[i]) | (~(xr[i] ^ yr[i]) & bchain);
    end
    b_nx   = bchain;
    cat    = {ds, res};
    res_nx = cat[WIDTH+DIGIT-1:DIGIT];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit-serial datapath and result shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr   <= '0;
      yr   <= '0;
      res  <= '0;
      br   <= 1'b0;
      xmsb <= 1'b0;
      ymsb <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xr   <= X;
            yr   <= Y;
            br   <= Bin;
            xmsb <= X[WIDTH-1];
            ymsb <= Y[WIDTH-1];
            cnt  <= '0;
          end
        end
        RUN: begin
          xr  <= xr >> DIGIT;
          yr  <= yr >> DIGIT;
          res <= res_nx;
          br  <= b_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            D    <= res_nx;
            Bout <= b_nx;
            ovf  <= (xmsb != ymsb) && (res_nx[WIDTH-1] != xmsb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: table-driven vectors on an
// 8-bit/1-bit-digit instance, hand sequences for the protected window,
// mid-operation reset and held start, a 4-bit-digit instance, and an
// exhaustive sweep of a 4-bit instance against a reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;

  // Instance a: WIDTH=8, DIGIT=1
  logic       a_start = 1'b0, a_bin = 1'b0;
  logic [7:0] a_x = '0, a_y = '0, a_d;
  logic       a_ready, a_busy, a_done, a_bout, a_ovf;

  // Instance b: WIDTH=8, DIGIT=4
  logic       b_start = 1'b0, b_bin = 1'b0;
  logic [7:0] b_x = '0, b_y = '0, b_d;
  logic       b_ready, b_busy, b_done, b_bout, b_ovf;

  // Instance c: WIDTH=4, DIGIT=1
  logic       c_start = 1'b0, c_bin = 1'b0;
  logic [3:0] c_x = '0, c_y = '0, c_d;
  logic       c_ready, c_busy, c_done, c_bout, c_ovf;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .X(a_x), .Y(a_y), .Bin(a_bin),
    .ready(a_ready), .busy(a_busy), .done(a_done), .D(a_d), .Bout(a_bout), .ovf(a_ovf));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .X(b_x), .Y(b_y), .Bin(b_bin),
    .ready(b_ready), .busy(b_busy), .done(b_done), .D(b_d), .Bout(b_bout), .ovf(b_ovf));

  serial_subtractor #(.WIDTH(4), .DIGIT(1)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .X(c_x), .Y(c_y), .Bin(c_bin),
    .ready(c_ready), .busy(c_busy), .done(c_done), .D(c_d), .Bout(c_bout), .ovf(c_ovf));

  // Handshake invariants on every instance, sampled away from the edge.
  always @(negedge clk) begin
    if ((a_busy && a_ready) || (a_done && a_busy)) inv_bad++;
    if ((b_busy && b_ready) || (b_done && b_busy)) inv_bad++;
    if ((c_busy && c_ready) || (c_done && c_busy)) inv_bad++;
  end

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation on instance a; returns results seen in the done cycle and
  // the number of cycles after the accepting edge at which done was seen.
  task automatic run_a(input logic [7:0] x, input logic [7:0] y, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    a_x = x; a_y = y; a_bin = bin; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat = 1;
    while (a_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = a_d; bo = a_bout; ov = a_ovf;
    @(negedge clk);
    check("a_done_single_pulse", {30'd0, a_done, a_ready}, 32'h1);
  endtask

  task automatic run_b(input logic [7:0] x, input logic [7:0] y, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    b_x = x; b_y = y; b_bin = bin; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lat = 1;
    while (b_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = b_d; bo = b_bout; ov = b_ovf;
    @(negedge clk);
    check("b_done_single_pulse", {30'd0, b_done, b_ready}, 32'h1);
  endtask

  task automatic run_c(input logic [3:0] x, input logic [3:0] y, input logic bin,
                       output logic [3:0] d, output logic bo, output logic ov, output int lat);
    @(negedge clk);
    c_x = x; c_y = y; c_bin = bin; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    lat = 1;
    while (c_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = c_d; bo = c_bout; ov = c_ovf;
    @(negedge clk);
  endtask

  initial begin
    vec_t       tab[5];
    logic [7:0] d8;
    logic [3:0] d4;
    logic       bo, ov;
    int         lat, t1, t2, stable_bad, sweep_bad;

    tab[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tab[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tab[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tab[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tab[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_a_outputs", {20'd0, a_ready, a_busy, a_done, a_d, a_bout, a_ovf},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("idle_a_outputs", {20'd0, a_ready, a_busy, a_done, a_d, a_bout, a_ovf},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

    // Table vectors, DIGIT=1
    for (int i = 0; i < 5; i++) begin
      run_a(tab[i].x, tab[i].y, tab[i].bin, d8, bo, ov, lat);
      check($sformatf("a_vec%0d_result", i), {22'd0, d8, bo, ov},
            {22'd0, tab[i].d, tab[i].bout, tab[i].ovf});
      check($sformatf("a_vec%0d_latency", i), lat, 9);
    end

    // Protected window: D holds 0x80 through RUN, intruding start ignored
    @(negedge clk);
    a_x = 8'h05; a_y = 8'h03; a_bin = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat = 1;
    stable_bad = 0;
    while (a_done !== 1'b1 && lat < 40) begin
      if (a_d !== 8'h80) stable_bad++;
      if (lat == 3) begin
        a_x = 8'h10; a_y = 8'h01; a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    a_start = 1'b0;
    check("a_d_stable_during_run", stable_bad, 0);
    check("a_window_latency", lat, 9);
    check("a_window_result", {22'd0, a_d, a_bout, a_ovf}, {22'd0, 8'h02, 1'b0, 1'b0});
    repeat (4) @(negedge clk);
    check("a_no_queued_start", {30'd0, a_busy, a_ready}, 32'h1);
    check("a_result_held", {24'd0, a_d}, 32'h02);

    // Reset in the 4th RUN cycle aborts at once
    @(negedge clk);
    a_x = 8'h05; a_y = 8'h03; a_bin = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    check("a_busy_before_reset", {31'd0, a_busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("a_async_reset", {20'd0, a_ready, a_busy, a_done, a_d, a_bout, a_ovf},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    run_a(8'h0A, 8'h0B, 1'b0, d8, bo, ov, lat);
    check("a_after_reset_result", {22'd0, d8, bo, ov}, {22'd0, 8'hFF, 1'b1, 1'b0});
    check("a_after_reset_latency", lat, 9);

    // Held start relaunches every N+2 = 10 cycles
    @(negedge clk);
    a_x = 8'h05; a_y = 8'h03; a_bin = 1'b0; a_start = 1'b1;
    t1 = 0;
    while (a_done !== 1'b1 && t1 < 40) begin
      @(negedge clk);
      t1++;
    end
    t2 = 0;
    @(negedge clk);
    t2++;
    while (a_done !== 1'b1 && t2 < 40) begin
      @(negedge clk);
      t2++;
    end
    a_start = 1'b0;
    check("a_held_start_period", t2, 10);
    check("a_held_start_result", {24'd0, a_d}, 32'h02);
    repeat (3) @(negedge clk);

    // DIGIT=4 instance
    run_b(8'hC3, 8'h4D, 1'b1, d8, bo, ov, lat);
    check("b_result", {22'd0, d8, bo, ov}, {22'd0, 8'h75, 1'b0, 1'b1});
    check("b_latency", lat, 3);

    // Exhaustive 4-bit sweep against X - Y - Bin
    sweep_bad = 0;
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        for (int bi = 0; bi < 2; bi++) begin
          logic [3:0] xv, yv, ed;
          logic [4:0] diff;
          logic       bv, eb, eo;
          xv   = 4'(xi);
          yv   = 4'(yi);
          bv   = 1'(bi);
          diff = {1'b0, xv} - {1'b0, yv} - {4'd0, bv};
          ed   = diff[3:0];
          eb   = diff[4];
          eo   = (xv[3] != yv[3]) && (ed[3] != xv[3]);
          run_c(xv, yv, bv, d4, bo, ov, lat);
          checks++;
          if ({d4, bo, ov} !== {ed, eb, eo} || lat != 5) begin
            failures++;
            sweep_bad++;
            if (sweep_bad <= 8)
              $display("FAIL c_sweep x=%0h y=%0h bin=%0b: got d=%0h bout=%0b ovf=%0b lat=%0d, expected d=%0h bout=%0b ovf=%0b lat=5",
                       xv, yv, bv, d4, bo, ov, lat, ed, eb, eo);
          end
        end
      end
    end

    check("handshake_invariants", inv_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
